// File: rtl/gshare_pht_if.sv
// Fetch, prediction and training signals between the front end and the gshare PHT.
interface gshare_pht_if #(
  parameter int unsigned GHR_SIZE = 9
);
  logic                fetch_valid;
  logic [31:0]         fetch_pc1;
  logic [31:0]         fetch_pc2;
  logic                is_branch1;
  logic                is_branch2;
  logic [GHR_SIZE-1:0] ghr_in;
  logic                pred_branch1;
  logic                pred_branch2;
  logic                pred_taken1;
  logic                pred_taken2;
  logic [GHR_SIZE-1:0] pred_idx;
  logic [GHR_SIZE-1:0] pred_ghr_snap;
  logic                upd_valid;
  logic [GHR_SIZE-1:0] upd_idx;
  logic                upd_taken;
  logic                ready;

  modport master (
    output fetch_valid, fetch_pc1, fetch_pc2, is_branch1, is_branch2, ghr_in,
    output upd_valid, upd_idx, upd_taken,
    input  pred_branch1, pred_branch2, pred_taken1, pred_taken2, pred_idx, pred_ghr_snap,
    input  ready
  );

  modport slave (
    input  fetch_valid, fetch_pc1, fetch_pc2, is_branch1, is_branch2, ghr_in,
    input  upd_valid, upd_idx, upd_taken,
    output pred_branch1, pred_branch2, pred_taken1, pred_taken2, pred_idx, pred_ghr_snap,
    output ready
  );
endinterface

// File: rtl/gshare_pht.sv
// Gshare pattern history table: 2-bit saturating counters indexed by PC xor global history,
// with a reset-time initialization sweep before predictions and training are enabled.
module gshare_pht #(
  parameter int unsigned GHR_SIZE = 9,
  parameter logic [1:0]  INIT_CTR = 2'b01
) (
  input logic         CLK,
  input logic         reset,
  gshare_pht_if.slave pht
);
  localparam int unsigned PHT_ENTRIES = 2 ** GHR_SIZE;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e              state_q, state_d;
  logic [GHR_SIZE:0]   init_ptr_q, init_ptr_d;
  logic [1:0]          ctr_q [PHT_ENTRIES];

  logic                wr_en;
  logic [GHR_SIZE-1:0] wr_idx;
  logic [1:0]          wr_val;
  logic [1:0]          upd_ctr;
  logic [1:0]          upd_next;
  logic [GHR_SIZE-1:0] idx1;
  logic [GHR_SIZE-1:0] idx2;
  logic                run;

  assign idx1 = pht.fetch_pc1[GHR_SIZE+1:2] ^ pht.ghr_in;
  assign idx2 = pht.fetch_pc2[GHR_SIZE+1:2] ^ pht.ghr_in;

  // Ready is masked by reset so a reset asserted in StRun silences predictions immediately.
  assign run = (state_q == StRun) & ~reset;

  assign pht.ready         = run;
  assign pht.pred_branch1  = run & pht.fetch_valid & pht.is_branch1;
  assign pht.pred_branch2  = run & pht.fetch_valid & pht.is_branch2 & ~pht.is_branch1;
  assign pht.pred_taken1   = ctr_q[idx1][1];
  assign pht.pred_taken2   = ctr_q[idx2][1];
  assign pht.pred_idx      = pht.is_branch1 ? idx1 : idx2;
  assign pht.pred_ghr_snap = pht.ghr_in;

  always_comb begin
    upd_ctr  = ctr_q[pht.upd_idx];
    upd_next = upd_ctr;
    if (pht.upd_taken) begin
      if (upd_ctr != 2'b11) upd_next = upd_ctr + 2'd1;
    end else begin
      if (upd_ctr != 2'b00) upd_next = upd_ctr - 2'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    wr_en      = 1'b0;
    wr_idx     = pht.upd_idx;
    wr_val     = upd_next;
    unique case (state_q)
      StInit: begin
        wr_en      = 1'b1;
        wr_idx     = init_ptr_q[GHR_SIZE-1:0];
        wr_val     = INIT_CTR;
        init_ptr_d = init_ptr_q + (GHR_SIZE+1)'(1);
        // Extra pointer bit flags completion once the last entry has been written.
        if (init_ptr_d[GHR_SIZE]) state_d = StRun;
      end
      StRun: begin
        wr_en = pht.upd_valid;
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= StInit;
      init_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
    end
  end

  // The table itself is never cleared by reset; the sweep rewrites it.
  always_ff @(posedge CLK) begin
    if (!reset && wr_en) ctr_q[wr_idx] <= wr_val;
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pht.fetch_pc1[31:GHR_SIZE+2], pht.fetch_pc1[1:0],
                            pht.fetch_pc2[31:GHR_SIZE+2], pht.fetch_pc2[1:0]};
endmodule

// File: tb/tb_gshare_pht.sv
// Self-checking bench for gshare_pht: init sweep, training, arbitration, hazards, reset.
module tb_gshare_pht;
  logic CLK = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  int   exp_q[$];
  int   exp_v;

  always #5 CLK = ~CLK;

  gshare_pht_if #(.GHR_SIZE(9)) bus ();

  gshare_pht #(
    .GHR_SIZE(9),
    .INIT_CTR(2'b01)
  ) dut (
    .CLK  (CLK),
    .reset(reset),
    .pht  (bus)
  );

  task automatic set_fetch(input logic v, input logic b1, input logic b2,
                           input logic [31:0] pc1, input logic [31:0] pc2,
                           input logic [8:0] ghr);
    bus.fetch_valid = v;
    bus.is_branch1  = b1;
    bus.is_branch2  = b2;
    bus.fetch_pc1   = pc1;
    bus.fetch_pc2   = pc2;
    bus.ghr_in      = ghr;
  endtask

  task automatic do_update(input logic [8:0] idx, input logic taken);
    @(negedge CLK);
    bus.upd_valid = 1'b1;
    bus.upd_idx   = idx;
    bus.upd_taken = taken;
    @(negedge CLK);
    bus.upd_valid = 1'b0;
  endtask

  // Call at the negedge where reset was released; counts rising edges until ready.
  task automatic wait_ready(input bit pulse_upd, output int n, output int err);
    n   = 0;
    err = 0;
    #1;
    while (n < 2000 && bus.ready !== 1'b1) begin
      if (bus.pred_branch1 !== 1'b0) err = 1;
      bus.upd_valid = pulse_upd && n >= 200 && n < 210;
      bus.upd_idx   = 9'd6;
      bus.upd_taken = 1'b1;
      @(posedge CLK);
      #1;
      n++;
    end
    bus.upd_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge CLK);
    reset = 1'b1;
    set_fetch(1'b1, 1'b1, 1'b0, 32'h14, 32'h0, 9'h0A5);
    exp_q.push_back(0);
    exp_q.push_back(0);
    exp_q.push_back(9'h0A5);
    @(posedge CLK);
    #1;
    exp_v = exp_q.pop_front(); total++;
    if (bus.ready !== exp_v[0]) begin
      bad++; $display("FAIL reset_ready got=%b want=%0d", bus.ready, exp_v);
    end
    exp_v = exp_q.pop_front(); total++;
    if (bus.pred_branch1 !== exp_v[0]) begin
      bad++; $display("FAIL reset_pred_branch1 got=%b want=%0d", bus.pred_branch1, exp_v);
    end
    exp_v = exp_q.pop_front(); total++;
    if (bus.pred_ghr_snap !== exp_v[8:0]) begin
      bad++; $display("FAIL reset_ghr_snap got=%h want=%h", bus.pred_ghr_snap, exp_v);
    end
  endtask

  task automatic test_init;
    int n, err;
    int idxs[4] = '{0, 6, 255, 511};
    @(negedge CLK);
    reset = 1'b0;
    exp_q.push_back(512);
    exp_q.push_back(0);
    wait_ready(1'b0, n, err);
    exp_v = exp_q.pop_front(); total++;
    if (n !== exp_v) begin
      bad++; $display("FAIL init_cycles got=%0d want=%0d", n, exp_v);
    end
    exp_v = exp_q.pop_front(); total++;
    if (err !== exp_v) begin
      bad++; $display("FAIL init_pred_branch_quiet got=%0d want=%0d", err, exp_v);
    end
    foreach (idxs[i]) begin
      @(negedge CLK);
      set_fetch(1'b1, 1'b1, 1'b0, 32'(idxs[i]) << 2, 32'(idxs[i] ^ 1) << 2, 9'h000);
      exp_q.push_back({idxs[i], 3'b100});
      #1;
      exp_v = exp_q.pop_front(); total++;
      if ({23'b0, bus.pred_idx, bus.pred_branch1, bus.pred_taken1, bus.pred_taken2} !== exp_v)
      begin
        bad++; $display("FAIL init_read idx=%0d got=%h/%b%b%b want=%h", idxs[i], bus.pred_idx,
                        bus.pred_branch1, bus.pred_taken1, bus.pred_taken2, exp_v);
      end
    end
  endtask

  task automatic test_training;
    logic upd_dir[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic want_msb[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    @(negedge CLK);
    set_fetch(1'b1, 1'b1, 1'b0, 32'h14, 32'h0, 9'h003);
    foreach (upd_dir[i]) begin
      exp_q.push_back(int'(want_msb[i]));
      do_update(9'd6, upd_dir[i]);
      #1;
      exp_v = exp_q.pop_front(); total++;
      if (bus.pred_taken1 !== exp_v[0]) begin
        bad++; $display("FAIL train_step%0d got=%b want=%0d", i, bus.pred_taken1, exp_v);
      end
      if (i == 2) begin
        exp_q.push_back(6);
        exp_v = exp_q.pop_front(); total++;
        if (bus.pred_idx !== exp_v[8:0]) begin
          bad++; $display("FAIL train_pred_idx got=%0d want=%0d", bus.pred_idx, exp_v);
        end
      end
    end
  endtask

  task automatic test_hazard;
    @(negedge CLK);
    set_fetch(1'b1, 1'b1, 1'b0, 32'h14, 32'h0, 9'h003);
    bus.upd_valid = 1'b1;
    bus.upd_idx   = 9'd6;
    bus.upd_taken = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(1);
    #1;
    exp_v = exp_q.pop_front(); total++;
    if (bus.pred_taken1 !== exp_v[0]) begin
      bad++; $display("FAIL hazard_same_cycle got=%b want=%0d", bus.pred_taken1, exp_v);
    end
    @(negedge CLK);
    bus.upd_valid = 1'b0;
    #1;
    exp_v = exp_q.pop_front(); total++;
    if (bus.pred_taken1 !== exp_v[0]) begin
      bad++; $display("FAIL hazard_next_cycle got=%b want=%0d", bus.pred_taken1, exp_v);
    end
  endtask

  task automatic test_arbitration;
    @(negedge CLK);
    set_fetch(1'b1, 1'b1, 1'b1, 32'h14, 32'h20, 9'h003);
    exp_q.push_back({6, 2'b10});
    #1;
    exp_v = exp_q.pop_front(); total++;
    if ({21'b0, bus.pred_idx, bus.pred_branch1, bus.pred_branch2} !== exp_v) begin
      bad++; $display("FAIL arb_both got=%0d/%b%b want=%h", bus.pred_idx, bus.pred_branch1,
                      bus.pred_branch2, exp_v);
    end
    @(negedge CLK);
    set_fetch(1'b1, 1'b0, 1'b1, 32'h14, 32'h20, 9'h001);
    exp_q.push_back({9, 3'b010});
    #1;
    exp_v = exp_q.pop_front(); total++;
    if ({20'b0, bus.pred_idx, bus.pred_branch1, bus.pred_branch2, bus.pred_taken2} !== exp_v)
    begin
      bad++; $display("FAIL arb_slot2 got=%0d/%b%b%b want=%h", bus.pred_idx, bus.pred_branch1,
                      bus.pred_branch2, bus.pred_taken2, exp_v);
    end
  endtask

  task automatic test_fetch_invalid;
    @(negedge CLK);
    set_fetch(1'b0, 1'b1, 1'b0, 32'h14, 32'h0, 9'h003);
    exp_q.push_back({9'h003, 2'b00});
    #1;
    exp_v = exp_q.pop_front(); total++;
    if ({21'b0, bus.pred_ghr_snap, bus.pred_branch1, bus.pred_branch2} !== exp_v) begin
      bad++; $display("FAIL fetch_invalid got=%h/%b%b want=%h", bus.pred_ghr_snap,
                      bus.pred_branch1, bus.pred_branch2, exp_v);
    end
  endtask

  task automatic test_reset_mid_sweep;
    int n, err;
    @(negedge CLK);
    set_fetch(1'b1, 1'b1, 1'b0, 32'h14, 32'h0, 9'h003);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    repeat (100) @(posedge CLK);
    @(negedge CLK);
    reset = 1'b1;
    exp_q.push_back(0);
    #1;
    exp_v = exp_q.pop_front(); total++;
    if (bus.ready !== exp_v[0]) begin
      bad++; $display("FAIL midsweep_ready_in_reset got=%b want=%0d", bus.ready, exp_v);
    end
    @(negedge CLK);
    reset = 1'b0;
    exp_q.push_back(512);
    exp_q.push_back(0);
    wait_ready(1'b1, n, err);
    exp_v = exp_q.pop_front(); total++;
    if (n !== exp_v) begin
      bad++; $display("FAIL midsweep_cycles got=%0d want=%0d", n, exp_v);
    end
    exp_v = exp_q.pop_front(); total++;
    if (err !== exp_v) begin
      bad++; $display("FAIL midsweep_pred_quiet got=%0d want=%0d", err, exp_v);
    end
    exp_q.push_back(0);
    @(negedge CLK);
    #1;
    exp_v = exp_q.pop_front(); total++;
    if (bus.pred_taken1 !== exp_v[0]) begin
      bad++; $display("FAIL midsweep_upd_ignored got=%b want=%0d", bus.pred_taken1, exp_v);
    end
    // 01 -> 10 confirms the entry was restored to INIT_CTR rather than left at 00 or 11.
    exp_q.push_back(1);
    do_update(9'd6, 1'b1);
    #1;
    exp_v = exp_q.pop_front(); total++;
    if (bus.pred_taken1 !== exp_v[0]) begin
      bad++; $display("FAIL midsweep_ctr_value got=%b want=%0d", bus.pred_taken1, exp_v);
    end
  endtask

  initial begin
    reset         = 1'b0;
    bus.upd_valid = 1'b0;
    bus.upd_idx   = '0;
    bus.upd_taken = 1'b0;
    set_fetch(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 9'h000);
    test_reset();
    test_init();
    test_training();
    test_hazard();
    test_arbitration();
    test_fetch_invalid();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
